// File: rtl/laser_cover_param_if.sv
// -----------------------------------------------------------------------------
// laser_cover_param_if
// Bus bundle for the two-circle coverage optimiser.
//   master : target source / result consumer (drives IN_VALID, X, Y)
//   slave  : the optimiser (drives READY and the result bus)
// Signals:
//   IN_VALID, X, Y     target point handshake (accepted while READY=1)
//   READY              optimiser is in its load phase
//   C1X, C1Y, C2X, C2Y final circle centres
//   COVER              points covered by the final placement
//   ITER               rounds executed
//   CONVERGED          1 = last round changed nothing, 0 = round cap reached
//   DONE               single-cycle result strobe
// -----------------------------------------------------------------------------
interface laser_cover_param_if #(
   parameter int COORD_W = 4,
   parameter int CNT_W   = 6,
   parameter int IT_W    = 4
);
   logic               IN_VALID;
   logic [COORD_W-1:0] X;
   logic [COORD_W-1:0] Y;
   logic               READY;
   logic [COORD_W-1:0] C1X;
   logic [COORD_W-1:0] C1Y;
   logic [COORD_W-1:0] C2X;
   logic [COORD_W-1:0] C2Y;
   logic [CNT_W-1:0]   COVER;
   logic [IT_W-1:0]    ITER;
   logic               CONVERGED;
   logic               DONE;

   modport master (
      output IN_VALID, X, Y,
      input  READY, C1X, C1Y, C2X, C2Y, COVER, ITER, CONVERGED, DONE
   );

   modport slave (
      input  IN_VALID, X, Y,
      output READY, C1X, C1Y, C2X, C2Y, COVER, ITER, CONVERGED, DONE
   );
endinterface

// File: rtl/laser_cover_param.sv
// -----------------------------------------------------------------------------
// laser_cover_param
// Two-circle coverage optimiser. Loads NUM_TARGETS points, then alternately
// scans every grid position for circle 2 (circle 1 fixed) and circle 1
// (circle 2 fixed), keeping the earliest raster position with the highest
// coverage, until a round changes nothing or MAX_ITER rounds have run.
// Ports:
//   CLK  clock
//   RST  synchronous active-high reset; aborts any job without DONE
//   bus  slave side of laser_cover_param_if (target load + result bus)
// -----------------------------------------------------------------------------
module laser_cover_param #(
   parameter int NUM_TARGETS = 40,
   parameter int COORD_W     = 4,
   parameter int RADIUS      = 4,
   parameter int MAX_ITER    = 8,
   parameter int CNT_W       = $clog2(NUM_TARGETS+1),
   parameter int IT_W        = $clog2(MAX_ITER+1)
) (
   input  logic                  CLK,
   input  logic                  RST,
   laser_cover_param_if.slave    bus
);

   localparam int AW     = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
   localparam int DEPTH  = 2**AW;
   localparam int PH_W   = $clog2(NUM_TARGETS+1);
   localparam int SQ_W   = 2*COORD_W+1;
   localparam int R2_INT = RADIUS*RADIUS;
   localparam int SQ_MAX = (2**SQ_W)-1;
   // A radius whose square exceeds any reachable distance covers everything,
   // so clamping the constant to the sum width preserves the comparison.
   localparam logic [SQ_W-1:0]    R2       = (R2_INT > SQ_MAX) ? SQ_W'(SQ_MAX) : SQ_W'(R2_INT);
   localparam logic [COORD_W-1:0] CMAX     = '1;
   localparam logic [PH_W-1:0]    PH_EVAL  = PH_W'(NUM_TARGETS);
   localparam logic [PH_W-1:0]    PH_LAST  = PH_W'(NUM_TARGETS-1);
   localparam logic [AW-1:0]      LAST_IDX = AW'(NUM_TARGETS-1);
   localparam logic [IT_W-1:0]    ITER_CAP = IT_W'(MAX_ITER);

   typedef enum logic [2:0] {
      S_LOAD,
      S_INIT,
      S_SCAN_C2,
      S_SCAN_C1,
      S_CHECK,
      S_OUT
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // Target memory (block RAM, registered read)
   logic [COORD_W-1:0] r_mem_x [0:DEPTH-1];
   logic [COORD_W-1:0] r_mem_y [0:DEPTH-1];
   logic [COORD_W-1:0] r_rd_x;
   logic [COORD_W-1:0] r_rd_y;
   logic [AW-1:0]      r_load_cnt;
   logic [AW-1:0]      w_rd_addr;

   // Scan datapath
   logic [PH_W-1:0]    r_phase;
   logic [COORD_W-1:0] r_cx, r_cy;
   logic [CNT_W-1:0]   r_acc;
   logic [COORD_W-1:0] r_best_x, r_best_y;
   logic [CNT_W-1:0]   r_best_cnt;
   logic [COORD_W-1:0] r_c1x, r_c1y, r_c2x, r_c2y;
   logic [COORD_W-1:0] r_old_c1x, r_old_c1y, r_old_c2x, r_old_c2y;
   logic [IT_W-1:0]    r_iter;
   logic [CNT_W-1:0]   r_round_cov;

   // Result registers
   logic [COORD_W-1:0] r_out_c1x, r_out_c1y, r_out_c2x, r_out_c2y;
   logic [CNT_W-1:0]   r_out_cover;
   logic [IT_W-1:0]    r_out_iter;
   logic               r_out_conv;
   logic               r_done;

   logic               w_scanning;
   logic               w_eval;
   logic               w_scan_end;
   logic               w_load_last;
   logic [COORD_W-1:0] w_fx, w_fy;
   logic               w_hit;
   logic               w_take;
   logic [COORD_W-1:0] w_new_bx, w_new_by;
   logic [CNT_W-1:0]   w_new_bc;
   logic               w_changed;
   logic [IT_W-1:0]    w_iter_inc;

   function automatic logic in_circle(input logic [COORD_W-1:0] px, py, cx, cy);
      logic [COORD_W-1:0] dx;
      logic [COORD_W-1:0] dy;
      logic [SQ_W-1:0]    dx2;
      logic [SQ_W-1:0]    dy2;
      logic [SQ_W-1:0]    d2;
      dx  = (px >= cx) ? (px - cx) : (cx - px);
      dy  = (py >= cy) ? (py - cy) : (cy - py);
      dx2 = SQ_W'(dx) * SQ_W'(dx);
      dy2 = SQ_W'(dy) * SQ_W'(dy);
      d2  = dx2 + dy2;
      return (d2 <= R2);
   endfunction

   assign w_scanning  = (r_state == S_SCAN_C2) || (r_state == S_SCAN_C1);
   assign w_eval      = w_scanning && (r_phase == PH_EVAL);
   assign w_scan_end  = w_eval && (r_cx == CMAX) && (r_cy == CMAX);
   assign w_load_last = (r_state == S_LOAD) && bus.IN_VALID && (r_load_cnt == LAST_IDX);

   // The circle not being moved in the current scan
   assign w_fx = (r_state == S_SCAN_C2) ? r_c1x : r_c2x;
   assign w_fy = (r_state == S_SCAN_C2) ? r_c1y : r_c2y;

   // Read one target ahead so that target p sits in r_rd_* during phase p;
   // the last accumulate and the evaluation cycle prefetch target 0 for the
   // next candidate (or the next scan).
   assign w_rd_addr = (w_scanning && (r_phase < PH_LAST)) ? AW'(r_phase + 1'b1) : '0;

   assign w_hit = in_circle(r_rd_x, r_rd_y, w_fx, w_fy) |
                  in_circle(r_rd_x, r_rd_y, r_cx, r_cy);

   // Candidate (0,0) seeds the best; only a strictly better count replaces it
   assign w_take   = ((r_cx == '0) && (r_cy == '0)) || (r_acc > r_best_cnt);
   assign w_new_bx = w_take ? r_cx  : r_best_x;
   assign w_new_by = w_take ? r_cy  : r_best_y;
   assign w_new_bc = w_take ? r_acc : r_best_cnt;

   assign w_changed  = (r_c1x != r_old_c1x) || (r_c1y != r_old_c1y) ||
                       (r_c2x != r_old_c2x) || (r_c2y != r_old_c2y);
   assign w_iter_inc = r_iter + 1'b1;

   always_ff @(posedge CLK) begin
      if (!RST && (r_state == S_LOAD) && bus.IN_VALID) begin
         r_mem_x[r_load_cnt] <= bus.X;
         r_mem_y[r_load_cnt] <= bus.Y;
      end
      r_rd_x <= r_mem_x[w_rd_addr];
      r_rd_y <= r_mem_y[w_rd_addr];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_LOAD;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_LOAD:    if (w_load_last) w_state_next = S_INIT;
         S_INIT:    w_state_next = S_SCAN_C2;
         S_SCAN_C2: if (w_scan_end) w_state_next = S_SCAN_C1;
         S_SCAN_C1: if (w_scan_end) w_state_next = S_CHECK;
         S_CHECK: begin
            if (!w_changed || (w_iter_inc == ITER_CAP)) begin
               w_state_next = S_OUT;
            end else begin
               w_state_next = S_SCAN_C2;
            end
         end
         S_OUT:     w_state_next = S_LOAD;
         default:   w_state_next = S_LOAD;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_load_cnt  <= '0;
         r_phase     <= '0;
         r_done      <= 1'b0;
         r_out_c1x   <= '0;
         r_out_c1y   <= '0;
         r_out_c2x   <= '0;
         r_out_c2y   <= '0;
         r_out_cover <= '0;
         r_out_iter  <= '0;
         r_out_conv  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_LOAD: begin
               if (bus.IN_VALID) begin
                  r_load_cnt <= w_load_last ? '0 : (r_load_cnt + 1'b1);
               end
            end
            S_INIT: begin
               r_c1x     <= '0;
               r_c1y     <= '0;
               r_c2x     <= CMAX;
               r_c2y     <= CMAX;
               r_old_c1x <= '0;
               r_old_c1y <= '0;
               r_old_c2x <= CMAX;
               r_old_c2y <= CMAX;
               r_iter    <= '0;
               r_phase   <= '0;
               r_cx      <= '0;
               r_cy      <= '0;
            end
            S_SCAN_C2, S_SCAN_C1: begin
               if (!w_eval) begin
                  r_acc   <= ((r_phase == '0) ? '0 : r_acc) + CNT_W'(w_hit);
                  r_phase <= r_phase + 1'b1;
               end else begin
                  r_phase    <= '0;
                  r_best_x   <= w_new_bx;
                  r_best_y   <= w_new_by;
                  r_best_cnt <= w_new_bc;
                  // Raster advance, x inner; wraps to (0,0) after the last cell
                  if (r_cx == CMAX) begin
                     r_cx <= '0;
                     r_cy <= r_cy + 1'b1;
                  end else begin
                     r_cx <= r_cx + 1'b1;
                  end
                  if (w_scan_end) begin
                     if (r_state == S_SCAN_C2) begin
                        r_c2x <= w_new_bx;
                        r_c2y <= w_new_by;
                     end else begin
                        r_c1x       <= w_new_bx;
                        r_c1y       <= w_new_by;
                        r_round_cov <= w_new_bc;
                     end
                  end
               end
            end
            S_CHECK: begin
               r_iter  <= w_iter_inc;
               r_phase <= '0;
               r_cx    <= '0;
               r_cy    <= '0;
               if (!w_changed || (w_iter_inc == ITER_CAP)) begin
                  // Results become visible together with DONE in the OUT cycle
                  r_out_c1x   <= r_c1x;
                  r_out_c1y   <= r_c1y;
                  r_out_c2x   <= r_c2x;
                  r_out_c2y   <= r_c2y;
                  r_out_cover <= r_round_cov;
                  r_out_iter  <= w_iter_inc;
                  r_out_conv  <= !w_changed;
                  r_done      <= 1'b1;
               end else begin
                  r_old_c1x <= r_c1x;
                  r_old_c1y <= r_c1y;
                  r_old_c2x <= r_c2x;
                  r_old_c2y <= r_c2y;
               end
            end
            S_OUT: begin
               r_load_cnt <= '0;
            end
            default: begin
               r_load_cnt <= '0;
            end
         endcase
      end
   end

   assign bus.READY     = (r_state == S_LOAD);
   assign bus.C1X       = r_out_c1x;
   assign bus.C1Y       = r_out_c1y;
   assign bus.C2X       = r_out_c2x;
   assign bus.C2Y       = r_out_c2y;
   assign bus.COVER     = r_out_cover;
   assign bus.ITER      = r_out_iter;
   assign bus.CONVERGED = r_out_conv;
   assign bus.DONE      = r_done;

endmodule

// File: tb/tb_laser_cover_param.sv
// -----------------------------------------------------------------------------
// tb_laser_cover_param
// Two optimiser instances on a small grid: A with a round cap of 4, B with a
// round cap of 1. Jobs are loaded through a shared driver; expected results
// come from a plain behavioural model and are queued per instance, and a
// monitor per instance compares every DONE against the head of its queue.
// -----------------------------------------------------------------------------
module tb_laser_cover_param;
   localparam int NT   = 8;
   localparam int CW   = 3;
   localparam int RAD  = 2;
   localparam int MIA  = 4;
   localparam int MIB  = 1;
   localparam int CNTW = $clog2(NT+1);
   localparam int ITWA = $clog2(MIA+1);
   localparam int ITWB = $clog2(MIB+1);
   localparam int GMAX = (1 << CW) - 1;
   localparam int JOB_BUDGET = 6000;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          tb_valid = 1'b0;
   logic          tb_sel = 1'b0;
   logic [CW-1:0] tb_x = '0;
   logic [CW-1:0] tb_y = '0;

   always #5 CLK = ~CLK;

   laser_cover_param_if #(.COORD_W(CW), .CNT_W(CNTW), .IT_W(ITWA)) ifa ();
   laser_cover_param_if #(.COORD_W(CW), .CNT_W(CNTW), .IT_W(ITWB)) ifb ();

   assign ifa.IN_VALID = tb_valid & ~tb_sel;
   assign ifa.X        = tb_x;
   assign ifa.Y        = tb_y;
   assign ifb.IN_VALID = tb_valid & tb_sel;
   assign ifb.X        = tb_x;
   assign ifb.Y        = tb_y;

   laser_cover_param #(.NUM_TARGETS(NT), .COORD_W(CW), .RADIUS(RAD), .MAX_ITER(MIA)) dut_a (
      .CLK(CLK), .RST(RST), .bus(ifa)
   );
   laser_cover_param #(.NUM_TARGETS(NT), .COORD_W(CW), .RADIUS(RAD), .MAX_ITER(MIB)) dut_b (
      .CLK(CLK), .RST(RST), .bus(ifb)
   );

   typedef struct {
      int c1x; int c1y; int c2x; int c2y; int cov; int it; int conv;
   } res_t;

   int   n_checks = 0;
   int   n_err    = 0;
   res_t qa[$];
   res_t qb[$];
   int   px[NT];
   int   py[NT];
   int   done_cnt_a = 0;
   int   done_cnt_b = 0;
   res_t last_a;
   bit   have_last_a = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference ----------------
   function automatic int covered(int ax, int ay, int bx, int by);
      int n = 0;
      for (int i = 0; i < NT; i++) begin
         if (((px[i]-ax)*(px[i]-ax) + (py[i]-ay)*(py[i]-ay) <= RAD*RAD) ||
             ((px[i]-bx)*(px[i]-bx) + (py[i]-by)*(py[i]-by) <= RAD*RAD)) n++;
      end
      return n;
   endfunction

   function automatic res_t model(int maxit);
      res_t r;
      int o1x, o1y, o2x, o2y, bx, by, bc, n;
      r.c1x = 0; r.c1y = 0; r.c2x = GMAX; r.c2y = GMAX;
      r.cov = 0; r.it = 0; r.conv = 0;
      for (int k = 0; k < maxit; k++) begin
         o1x = r.c1x; o1y = r.c1y; o2x = r.c2x; o2y = r.c2y;
         bx = 0; by = 0; bc = -1;
         for (int y = 0; y <= GMAX; y++)
            for (int x = 0; x <= GMAX; x++) begin
               n = covered(r.c1x, r.c1y, x, y);
               if (n > bc) begin bc = n; bx = x; by = y; end
            end
         r.c2x = bx; r.c2y = by;
         bx = 0; by = 0; bc = -1;
         for (int y = 0; y <= GMAX; y++)
            for (int x = 0; x <= GMAX; x++) begin
               n = covered(x, y, r.c2x, r.c2y);
               if (n > bc) begin bc = n; bx = x; by = y; end
            end
         r.c1x = bx; r.c1y = by; r.cov = bc;
         r.it = k + 1;
         if (r.c1x == o1x && r.c1y == o1y && r.c2x == o2x && r.c2y == o2y) begin
            r.conv = 1;
            break;
         end
      end
      return r;
   endfunction

   // ---------------- monitors ----------------
   task automatic check_res(input string tag, input res_t e, input res_t a);
      chk({tag, "_c1x"},  a.c1x,  e.c1x);
      chk({tag, "_c1y"},  a.c1y,  e.c1y);
      chk({tag, "_c2x"},  a.c2x,  e.c2x);
      chk({tag, "_c2y"},  a.c2y,  e.c2y);
      chk({tag, "_cover"}, a.cov, e.cov);
      chk({tag, "_iter"}, a.it,   e.it);
      chk({tag, "_conv"}, a.conv, e.conv);
   endtask

   initial begin : mon_a
      res_t e;
      res_t a;
      int   prev = 0;
      forever begin
         @(negedge CLK);
         if (ifa.DONE === 1'b1) begin
            chk("a_done_single_cycle", prev, 0);
            a.c1x = int'(ifa.C1X); a.c1y = int'(ifa.C1Y);
            a.c2x = int'(ifa.C2X); a.c2y = int'(ifa.C2Y);
            a.cov = int'(ifa.COVER); a.it = int'(ifa.ITER); a.conv = int'(ifa.CONVERGED);
            if (qa.size() == 0) begin
               n_checks++; n_err++;
               $display("FAIL a_unexpected_done: got DONE required none (t=%0t)", $time);
            end else begin
               e = qa.pop_front();
               check_res("a", e, a);
            end
            $display("A done: C1=(%0d,%0d) C2=(%0d,%0d) COVER=%0d ITER=%0d CONV=%0d",
                     a.c1x, a.c1y, a.c2x, a.c2y, a.cov, a.it, a.conv);
            done_cnt_a++;
         end
         prev = (ifa.DONE === 1'b1) ? 1 : 0;
      end
   end

   initial begin : mon_b
      res_t e;
      res_t a;
      int   prev = 0;
      forever begin
         @(negedge CLK);
         if (ifb.DONE === 1'b1) begin
            chk("b_done_single_cycle", prev, 0);
            a.c1x = int'(ifb.C1X); a.c1y = int'(ifb.C1Y);
            a.c2x = int'(ifb.C2X); a.c2y = int'(ifb.C2Y);
            a.cov = int'(ifb.COVER); a.it = int'(ifb.ITER); a.conv = int'(ifb.CONVERGED);
            if (qb.size() == 0) begin
               n_checks++; n_err++;
               $display("FAIL b_unexpected_done: got DONE required none (t=%0t)", $time);
            end else begin
               e = qb.pop_front();
               check_res("b", e, a);
            end
            $display("B done: C1=(%0d,%0d) C2=(%0d,%0d) COVER=%0d ITER=%0d CONV=%0d",
                     a.c1x, a.c1y, a.c2x, a.c2y, a.cov, a.it, a.conv);
            done_cnt_b++;
         end
         prev = (ifb.DONE === 1'b1) ? 1 : 0;
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic int sel_ready(bit sel);
      return sel ? int'(ifb.READY) : int'(ifa.READY);
   endfunction

   task automatic load_job(input bit sel, input int gap_at, input int gap_len, input bit push);
      res_t e;
      for (int k = 0; k < 50; k++) begin
         @(negedge CLK);
         if (sel_ready(sel) == 1) break;
      end
      chk("ready_before_load", sel_ready(sel), 1);
      for (int i = 0; i < NT; i++) begin
         @(posedge CLK); #1;
         tb_sel = sel; tb_valid = 1'b1;
         tb_x = CW'(px[i]); tb_y = CW'(py[i]);
         if (i == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               @(posedge CLK); #1;
               tb_valid = 1'b0;
               tb_x = CW'($urandom); tb_y = CW'($urandom);
               @(negedge CLK);
               chk("ready_in_gap", sel_ready(sel), 1);
            end
         end
      end
      @(posedge CLK); #1;
      tb_valid = 1'b0;
      tb_x = CW'($urandom); tb_y = CW'($urandom);
      @(negedge CLK);
      chk("ready_drop_after_last", sel_ready(sel), 0);
      if (push) begin
         e = model(sel ? MIB : MIA);
         if (sel) qb.push_back(e);
         else begin
            qa.push_back(e);
            last_a = e;
         end
      end
   endtask

   task automatic wait_done(input bit sel, input res_t prev_res, input bit hold_chk);
      int start;
      bit seen = 1'b0;
      start = sel ? done_cnt_b : done_cnt_a;
      for (int k = 0; k < JOB_BUDGET; k++) begin
         @(negedge CLK);
         if (hold_chk && k == 100) begin
            chk("hold_c1x", int'(ifa.C1X), prev_res.c1x);
            chk("hold_c1y", int'(ifa.C1Y), prev_res.c1y);
            chk("hold_c2x", int'(ifa.C2X), prev_res.c2x);
            chk("hold_c2y", int'(ifa.C2Y), prev_res.c2y);
            chk("hold_cover", int'(ifa.COVER), prev_res.cov);
            chk("hold_iter", int'(ifa.ITER), prev_res.it);
         end
         #1;
         if ((sel ? done_cnt_b : done_cnt_a) != start) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_checks++; n_err++;
         $display("FAIL done_timeout: got no DONE within %0d cycles required DONE", JOB_BUDGET);
      end else begin
         @(negedge CLK);
         chk("ready_after_done", sel_ready(sel), 1);
      end
   endtask

   task automatic run_a(input int gap_at, input int gap_len);
      res_t prev;
      bit   hold;
      prev = last_a;
      hold = have_last_a;
      load_job(1'b0, gap_at, gap_len, 1'b1);
      wait_done(1'b0, prev, hold);
      have_last_a = 1'b1;
   endtask

   task automatic fill_cluster();
      for (int i = 0; i < NT; i++) begin px[i] = 3; py[i] = 3; end
   endtask

   task automatic fill_two_clusters();
      for (int i = 0; i < NT; i++) begin
         px[i] = (i < NT/2) ? 1 : 6;
         py[i] = (i < NT/2) ? 1 : 6;
      end
   endtask

   task automatic fill_random(input bit clustered);
      int cx0, cy0, cx1, cy1;
      cx0 = int'($urandom_range(0, GMAX)); cy0 = int'($urandom_range(0, GMAX));
      cx1 = int'($urandom_range(0, GMAX)); cy1 = int'($urandom_range(0, GMAX));
      for (int i = 0; i < NT; i++) begin
         if (clustered) begin
            px[i] = (i % 2 == 0) ? cx0 : cx1;
            py[i] = (i % 2 == 0) ? cy0 : cy1;
            px[i] = px[i] + int'($urandom_range(0, 2)) - 1;
            py[i] = py[i] + int'($urandom_range(0, 2)) - 1;
            if (px[i] < 0) px[i] = 0;
            if (py[i] < 0) py[i] = 0;
            if (px[i] > GMAX) px[i] = GMAX;
            if (py[i] > GMAX) py[i] = GMAX;
         end else begin
            px[i] = int'($urandom_range(0, GMAX));
            py[i] = int'($urandom_range(0, GMAX));
         end
      end
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_ready"}, int'(ifa.READY), 1);
      chk({tag, "_done"}, int'(ifa.DONE), 0);
      chk({tag, "_c1x"}, int'(ifa.C1X), 0);
      chk({tag, "_c1y"}, int'(ifa.C1Y), 0);
      chk({tag, "_c2x"}, int'(ifa.C2X), 0);
      chk({tag, "_c2y"}, int'(ifa.C2Y), 0);
      chk({tag, "_cover"}, int'(ifa.COVER), 0);
      chk({tag, "_iter"}, int'(ifa.ITER), 0);
      chk({tag, "_conv"}, int'(ifa.CONVERGED), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin : stim
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_cleared("reset");
      chk("reset_b_ready", int'(ifb.READY), 1);
      @(posedge CLK); #1;
      RST = 1'b0;

      // Single cluster, then two clusters back to back (hold checked in between)
      fill_cluster();
      run_a(-1, 0);
      fill_two_clusters();
      run_a(-1, 0);

      // Handshake gap with garbage on X/Y
      fill_two_clusters();
      run_a(NT/2 + 1, 5);

      // Randomised jobs with random gaps
      for (int j = 0; j < 4; j++) begin
         fill_random(j[0]);
         run_a(int'($urandom_range(0, NT-2)), int'($urandom_range(1, 5)));
      end

      // Reset during the circle-1 scan: job aborted, outputs cleared
      fill_cluster();
      load_job(1'b0, -1, 0, 1'b0);
      repeat (800) @(posedge CLK);
      #1 RST = 1'b1;
      @(posedge CLK); #1 RST = 1'b0;
      @(negedge CLK);
      check_cleared("midscan_reset");
      have_last_a = 1'b0;
      fill_two_clusters();
      run_a(-1, 0);

      // Round cap of 1 on the second instance
      fill_cluster();
      load_job(1'b1, -1, 0, 1'b1);
      wait_done(1'b1, last_a, 1'b0);
      fill_random(1'b0);
      load_job(1'b1, 2, 3, 1'b1);
      wait_done(1'b1, last_a, 1'b0);

      repeat (5) @(negedge CLK);
      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/laser_cover_param.md
Name: laser_cover_param

Overview:
- Parametrised two-circle coverage optimiser for the laser-targeting datapath.
- Loads NUM_TARGETS points over a valid handshake, then places two circles of radius RADIUS on a 2^COORD_W x 2^COORD_W grid to maximise the number of covered points.
- Placement uses alternating exhaustive grid scans (circle 2 first, then circle 1), repeated until the positions stop changing or MAX_ITER rounds complete.
- Reports both centres, the coverage count, the round count and a convergence flag.

Parameters:
- NUM_TARGETS, 40, number of points per problem set (>=1).
- COORD_W, 4, coordinate width in bits; the grid is 0..2^COORD_W-1 on each axis.
- RADIUS, 4, circle radius in grid units. A point is covered when dx^2+dy^2 <= RADIUS^2.
- MAX_ITER, 8, maximum number of rounds (>=1). One round is a C2 scan followed by a C1 scan.
- CNT_W = $clog2(NUM_TARGETS+1), derived, width of the coverage count.
- IT_W = $clog2(MAX_ITER+1), derived, width of the round count.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- IN_VALID  in  1  the X/Y pair is valid this cycle.
- X  in  COORD_W  target x coordinate.
- Y  in  COORD_W  target y coordinate.
- READY  out  1  high while the block accepts targets (LOAD state).
- C1X, C1Y, C2X, C2Y  out  COORD_W each  final circle centres.
- COVER  out  CNT_W  number of points covered by the final placement.
- ITER  out  IT_W  number of rounds executed.
- CONVERGED  out  1  1 = the last round produced no change; 0 = stopped by MAX_ITER.
- DONE  out  1  single-cycle result strobe.

Behaviour:
- Reset:
  - All outputs are 0, except READY=1.
  - State goes to LOAD and the load counter is cleared.
  - Reset asserted in any state, including mid-scan, aborts the current job with no DONE. Target memory contents are don't-care.
- LOAD:
  - A point is stored at index load_cnt, and load_cnt increments, on each cycle with IN_VALID=1.
  - IN_VALID=0 cycles are ignored; gaps are allowed.
  - The cycle that accepts point NUM_TARGETS-1 moves to INIT; READY drops on the following cycle.
  - IN_VALID is ignored in every state other than LOAD.
- INIT (1 cycle): C1=(0,0), C2=(max,max), where max=2^COORD_W-1. Round counter=0.
- SCAN_C2 / SCAN_C1:
  - Candidates are visited in raster order, x inner and y outer, from (0,0) to (max,max).
  - Each candidate takes NUM_TARGETS cycles of accumulation, one target per cycle, plus 1 evaluation cycle, for NUM_TARGETS+1 cycles per candidate.
  - A target counts when it is inside the fixed circle OR inside the candidate circle.
  - Candidate (0,0) always initialises the best; later candidates replace it only on a strictly greater count, so ties keep the earliest in raster order.
  - At the end of SCAN_C2, C2 takes the best candidate and the state moves to SCAN_C1.
  - At the end of SCAN_C1, C1 takes the best candidate, its count is latched as the round's coverage, and the state moves to CHECK.
- Distance arithmetic:
  - dx and dy are absolute differences, COORD_W bits, unsigned.
  - Squares and their sum are computed in 2*COORD_W+1 bits, with no overflow or truncation allowed.
  - The compare is against the constant RADIUS*RADIUS.
- CHECK (1 cycle):
  - Round counter increments.
  - If neither centre changed versus the start of the round, go to OUT with CONVERGED=1.
  - Else if the round counter has reached MAX_ITER, go to OUT with CONVERGED=0.
  - Otherwise snapshot the current centres as the new "old" values and go to SCAN_C2.
- OUT (1 cycle):
  - Registers C1X..C2Y, COVER, ITER and CONVERGED; DONE=1 for this cycle only.
  - Next state is LOAD with load_cnt=0 and READY=1 on the next cycle.
  - Result outputs hold their values until the next DONE or reset.
- DONE is never asserted for two consecutive cycles.

Test Plan:
1. Cluster convergence: 40 points at (3,3), defaults -> DONE once; C1=(0,0), C2=(1,0), COVER=40, ITER=2, CONVERGED=1.
2. Two clusters: 20 points at (2,2) and 20 at (12,12) -> C1=(0,0), C2=(12,8), COVER=40, ITER=2, CONVERGED=1.
3. Iteration cap: the scenario 1 data with MAX_ITER=1 -> C1=(0,0), C2=(1,0), COVER=40, ITER=1, CONVERGED=0.
4. Handshake gaps: scenario 2 data with IN_VALID low for 5 cycles after point 17 and X/Y driven to garbage during the gap -> results identical to scenario 2; READY high throughout the gap.
5. Reset mid-scan: assert RST during SCAN_C1 of scenario 1 -> next cycle READY=1, DONE=0, all result outputs 0; reloading the scenario 2 data then gives the scenario 2 results.
6. Back-to-back jobs: scenario 1 then scenario 2 without reset -> READY=1 the cycle after the first DONE; the second DONE carries scenario 2 values; scenario 1 values are held in between.
